// File: rtl/isa_wait_state_gen.sv
// isa_wait_state_gen: ISA bus wait-state generator feeding the chipset READY logic.
// Inserts IO_WAIT clocks on CPU I/O cycles and MEM_WAIT clocks on CPU memory
// cycles whose address[19:16] lies in [MEM_WIN_LO, MEM_WIN_HI], then merges in
// the expansion-card ready line.
// Optional watchdog: define ISA_WAIT_TIMEOUT_EN to force ready high after
// TIMEOUT_CYCLES consecutive card-not-ready clocks.
// Ports:
//   clock, reset              bus clock, synchronous active-high reset
//   address[19:0]             latched bus address
//   io_read_n, io_write_n,
//   memory_read_n,
//   memory_write_n            active-low command strobes
//   address_enable_n          0 = CPU cycle, 1 = DMA cycle
//   io_channel_ready_ext      wired ready from the cards
//   io_channel_ready          merged ready to the chipset (combinational)
//   wait_active               internal wait states in progress (combinational)
//   bus_timeout               one-clock pulse when the watchdog fires
module isa_wait_state_gen #(
  parameter int unsigned IO_WAIT        = 2,
  parameter int unsigned MEM_WAIT       = 1,
  parameter logic [3:0]  MEM_WIN_LO     = 4'hA,
  parameter logic [3:0]  MEM_WIN_HI     = 4'hB,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [19:0] address,
  input  logic        io_read_n,
  input  logic        io_write_n,
  input  logic        memory_read_n,
  input  logic        memory_write_n,
  input  logic        address_enable_n,
  input  logic        io_channel_ready_ext,
  output logic        io_channel_ready,
  output logic        wait_active,
  output logic        bus_timeout
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] IO_LOAD  = CNT_W'(IO_WAIT);
  localparam logic [CNT_W-1:0] MEM_LOAD = CNT_W'(MEM_WAIT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_EXT  = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [CNT_W-1:0] load;
  logic             cmd, cmd_d, cmd_rise, io_cmd, in_win;
  logic             timed_out;
  logic             unused_addr;

  // Only the top address nibble selects the memory wait window.
  assign unused_addr = &{1'b0, address[15:0]};

  // Command decode and strobe-edge detect.
  assign cmd      = ~(io_read_n & io_write_n & memory_read_n & memory_write_n);
  assign cmd_rise = cmd & ~cmd_d;
  assign io_cmd   = ~(io_read_n & io_write_n);
  assign in_win   = (address[19:16] >= MEM_WIN_LO) && (address[19:16] <= MEM_WIN_HI);

  // Wait-state count for the starting cycle; DMA never gets internal waits.
  always_comb begin
    load = '0;
    if (!address_enable_n) begin
      if (io_cmd)      load = IO_LOAD;
      else if (in_win) load = MEM_LOAD;
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      cmd_d <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      cmd_d <= cmd;
    end
  end

  // Next state and merged ready. The strobe-edge clock is itself the first
  // wait clock, so cnt counts the WAIT-state clocks remaining after it;
  // a load of 1 therefore needs no WAIT state at all.
  always_comb begin
    state_next       = state;
    cnt_next         = cnt;
    io_channel_ready = io_channel_ready_ext;
    wait_active      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_rise) begin
          if (load > CNT_W'(1)) begin
            state_next       = ST_WAIT;
            cnt_next         = CNT_W'(load - CNT_W'(2));
            io_channel_ready = 1'b0;
            wait_active      = 1'b1;
          end else if (load == CNT_W'(1)) begin
            state_next       = ST_EXT;
            cnt_next         = '0;
            io_channel_ready = 1'b0;
            wait_active      = 1'b1;
          end else begin
            state_next = ST_EXT;
          end
        end
      end
      ST_WAIT: begin
        io_channel_ready = 1'b0;
        wait_active      = 1'b1;
        if (!cmd) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else if (cnt == '0) begin
          state_next = ST_EXT;
        end else begin
          cnt_next = CNT_W'(cnt - CNT_W'(1));
        end
      end
      ST_EXT: begin
        io_channel_ready = io_channel_ready_ext | timed_out;
        if (!cmd) state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
    if (reset) begin
      io_channel_ready = 1'b1;
      wait_active      = 1'b0;
    end
  end

`ifdef ISA_WAIT_TIMEOUT_EN
  localparam int unsigned TMO_W = 8;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo;
  logic             tmo_fire;

  // Fires on the edge that completes TIMEOUT_CYCLES consecutive ext-low clocks.
  assign tmo_fire = (state == ST_EXT) && cmd && !io_channel_ready_ext &&
                    !timed_out && (tmo == TMO_LAST);

  // Watchdog counter and sticky timeout flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      tmo         <= '0;
      timed_out   <= 1'b0;
      bus_timeout <= 1'b0;
    end else begin
      bus_timeout <= tmo_fire;
      if ((state != ST_EXT) || io_channel_ready_ext || timed_out) tmo <= '0;
      else                                                          tmo <= TMO_W'(tmo + TMO_W'(1));
      if ((state == ST_EXT) && !cmd) timed_out <= 1'b0;
      else if (tmo_fire)             timed_out <= 1'b1;
    end
  end
`else
  logic [7:0] unused_tmo_cfg;

  assign unused_tmo_cfg = 8'(TIMEOUT_CYCLES);
  assign timed_out      = 1'b0;
  assign bus_timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_isa_wait_state_gen.sv
// Directed bench for isa_wait_state_gen. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge.
module tb_isa_wait_state_gen;

  logic        clock;
  logic        reset;
  logic [19:0] address;
  logic        io_read_n, io_write_n, memory_read_n, memory_write_n;
  logic        address_enable_n;
  logic        io_channel_ready_ext;
  logic        io_channel_ready, wait_active, bus_timeout;
  logic        ready5, wait5, timeout5;

  int checks   = 0;
  int failures = 0;

  isa_wait_state_gen #(
    .IO_WAIT(2), .MEM_WAIT(1), .MEM_WIN_LO(4'hA), .MEM_WIN_HI(4'hB), .TIMEOUT_CYCLES(8)
  ) u_dut (
    .clock(clock), .reset(reset), .address(address),
    .io_read_n(io_read_n), .io_write_n(io_write_n),
    .memory_read_n(memory_read_n), .memory_write_n(memory_write_n),
    .address_enable_n(address_enable_n), .io_channel_ready_ext(io_channel_ready_ext),
    .io_channel_ready(io_channel_ready), .wait_active(wait_active), .bus_timeout(bus_timeout)
  );

  isa_wait_state_gen #(
    .IO_WAIT(5), .MEM_WAIT(1), .MEM_WIN_LO(4'hA), .MEM_WIN_HI(4'hB), .TIMEOUT_CYCLES(200)
  ) u_dut5 (
    .clock(clock), .reset(reset), .address(address),
    .io_read_n(io_read_n), .io_write_n(io_write_n),
    .memory_read_n(memory_read_n), .memory_write_n(memory_write_n),
    .address_enable_n(address_enable_n), .io_channel_ready_ext(io_channel_ready_ext),
    .io_channel_ready(ready5), .wait_active(wait5), .bus_timeout(timeout5)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_bit(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // One bus clock on the main instance: check at negedge, then advance.
  task automatic cyc(input string tag, input logic er, input logic ew, input logic et);
    @(negedge clock);
    check_bit({tag, ".ready"}, io_channel_ready, er);
    check_bit({tag, ".wait"},  wait_active,      ew);
    check_bit({tag, ".tmo"},   bus_timeout,      et);
    @(posedge clock); #1;
  endtask

  // One bus clock on the IO_WAIT=5 instance.
  task automatic cyc5(input string tag, input logic er, input logic ew);
    @(negedge clock);
    check_bit({tag, ".ready5"}, ready5,   er);
    check_bit({tag, ".wait5"},  wait5,    ew);
    check_bit({tag, ".tmo5"},   timeout5, 1'b0);
    @(posedge clock); #1;
  endtask

  task automatic idle_clk();
    io_read_n = 1'b1; io_write_n = 1'b1; memory_read_n = 1'b1; memory_write_n = 1'b1;
    @(posedge clock); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    reset = 1'b1; address = 20'h0; address_enable_n = 1'b0; io_channel_ready_ext = 1'b1;
    io_read_n = 1'b1; io_write_n = 1'b1; memory_read_n = 1'b1; memory_write_n = 1'b1;
    @(posedge clock); #1;
    cyc("reset", 1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    cyc("idle", 1'b1, 1'b0, 1'b0);

    // CPU I/O read, two waits, then ext passes through in EXT.
    address = 20'h003F8; io_read_n = 1'b0;
    cyc("io_c0", 1'b0, 1'b1, 1'b0);
    cyc("io_c1", 1'b0, 1'b1, 1'b0);
    cyc("io_c2", 1'b1, 1'b0, 1'b0);
    io_channel_ready_ext = 1'b0;
    cyc("io_ext_lo", 1'b0, 1'b0, 1'b0);
    io_channel_ready_ext = 1'b1;
    cyc("io_ext_hi", 1'b1, 1'b0, 1'b0);
    idle_clk(); idle_clk();

    // Memory read inside the window: one wait.
    address = 20'hB8000; memory_read_n = 1'b0;
    cyc("memB8_c0", 1'b0, 1'b1, 1'b0);
    cyc("memB8_c1", 1'b1, 1'b0, 1'b0);
    idle_clk(); idle_clk();

    // Lower window edge.
    address = 20'hA0000; memory_write_n = 1'b0;
    cyc("memA0_c0", 1'b0, 1'b1, 1'b0);
    cyc("memA0_c1", 1'b1, 1'b0, 1'b0);
    idle_clk(); idle_clk();

    // Outside the window: no waits.
    address = 20'h12345; memory_read_n = 1'b0;
    cyc("mem12_c0", 1'b1, 1'b0, 1'b0);
    idle_clk(); idle_clk();
    address = 20'hC0000; memory_read_n = 1'b0;
    cyc("memC0_c0", 1'b1, 1'b0, 1'b0);
    idle_clk(); idle_clk();

    // I/O wins over a simultaneous memory strobe in the window.
    address = 20'hA0000; io_write_n = 1'b0; memory_read_n = 1'b0;
    cyc("iomem_c0", 1'b0, 1'b1, 1'b0);
    cyc("iomem_c1", 1'b0, 1'b1, 1'b0);
    cyc("iomem_c2", 1'b1, 1'b0, 1'b0);
    idle_clk(); idle_clk();

    // DMA I/O write: no internal waits, ready mirrors ext.
    address = 20'h00060; address_enable_n = 1'b1; io_write_n = 1'b0; io_channel_ready_ext = 1'b0;
    cyc("dma_c0", 1'b0, 1'b0, 1'b0);
    cyc("dma_c1", 1'b0, 1'b0, 1'b0);
    cyc("dma_c2", 1'b0, 1'b0, 1'b0);
    io_channel_ready_ext = 1'b1;
    cyc("dma_c3", 1'b1, 1'b0, 1'b0);
    address_enable_n = 1'b0;
    idle_clk(); idle_clk();

    // Abort on the IO_WAIT=5 instance, then a fresh full sequence.
    address = 20'h00300; io_read_n = 1'b0;
    cyc5("ab_c0", 1'b0, 1'b1);
    cyc5("ab_c1", 1'b0, 1'b1);
    io_read_n = 1'b1;
    cyc5("ab_rel", 1'b0, 1'b1);
    cyc5("ab_idle", 1'b1, 1'b0);
    io_read_n = 1'b0;
    for (int i = 0; i < 5; i++) cyc5($sformatf("full_w%0d", i), 1'b0, 1'b1);
    cyc5("full_done", 1'b1, 1'b0);
    idle_clk(); idle_clk();

    // Watchdog: card holds ready low through the whole cycle.
    address = 20'h00310; io_read_n = 1'b0; io_channel_ready_ext = 1'b0;
    cyc("wd_w0", 1'b0, 1'b1, 1'b0);
    cyc("wd_w1", 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) cyc($sformatf("wd_ext%0d", i), 1'b0, 1'b0, 1'b0);
`ifdef ISA_WAIT_TIMEOUT_EN
    cyc("wd_fire", 1'b1, 1'b0, 1'b1);
    cyc("wd_hold", 1'b1, 1'b0, 1'b0);
    io_read_n = 1'b1;
    cyc("wd_rel", 1'b1, 1'b0, 1'b0);
`else
    cyc("wd_fire", 1'b0, 1'b0, 1'b0);
    cyc("wd_hold", 1'b0, 1'b0, 1'b0);
    io_read_n = 1'b1;
    cyc("wd_rel", 1'b0, 1'b0, 1'b0);
`endif
    cyc("wd_idle", 1'b0, 1'b0, 1'b0);
    io_channel_ready_ext = 1'b1;
    idle_clk(); idle_clk();

    // Reset during WAIT with the strobe held low.
    io_read_n = 1'b0;
    cyc("rw_c0", 1'b0, 1'b1, 1'b0);
    reset = 1'b1;
    cyc("rw_rst", 1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    cyc("rw_a0", 1'b0, 1'b1, 1'b0);
    cyc("rw_a1", 1'b0, 1'b1, 1'b0);
    cyc("rw_a2", 1'b1, 1'b0, 1'b0);
    idle_clk();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
